// File: rtl/accel_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : accel_rr_scheduler
//  Description : Round-robin scheduler that time-shares one start/finish
//                style accelerator among NUM_REQ requesters. It grants one
//                requester at a time, measures the run length, optionally
//                aborts runs that exceed TIMEOUT, and reports each result
//                with a one-cycle ack/rsp_valid pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module accel_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CYC_W   = 32,
    parameter int TIMEOUT = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] ack,
    output logic               rsp_valid,
    output logic [ID_W-1:0]    rsp_id,
    output logic [31:0]        rsp_val,
    output logic [CYC_W-1:0]   rsp_cycles,
    output logic               rsp_timeout,
    output logic               acc_start,
    output logic               acc_reset,
    input  logic               acc_finish,
    input  logic [31:0]        acc_return_val,
    output logic               busy,
    output logic [1:0]         state
);

    // FSM encoding is visible on the state port for LED debug
    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_exe   = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    // A zero TIMEOUT disables run abort entirely
    localparam logic             c_to_en     = (TIMEOUT != 0);
    localparam logic [CYC_W-1:0] c_to_last   = CYC_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CYC_W-1:0] c_to_cycles = CYC_W'(TIMEOUT);
    localparam logic [CYC_W-1:0] c_cnt_max   = '1;

    logic [1:0]         r_state;
    logic [ID_W-1:0]    r_grant_id;
    logic [ID_W-1:0]    r_last_grant;
    logic [CYC_W-1:0]   r_cnt;
    logic [ID_W-1:0]    r_rsp_id;
    logic [31:0]        r_rsp_val;
    logic [CYC_W-1:0]   r_rsp_cycles;
    logic               r_rsp_timeout;
    logic               r_rsp_valid;
    logic [NUM_REQ-1:0] r_ack;
    logic               r_acc_start;

    logic               w_found;
    logic [ID_W-1:0]    w_pick;
    int                 w_idx;
    logic [CYC_W-1:0]   w_cnt_inc;
    logic [NUM_REQ-1:0] w_grant_onehot;

    // Round-robin search starting just after the last served requester,
    // so a requester that was just served is considered last
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = int'(r_last_grant) + i;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = ID_W'(w_idx);
            end
        end
    end

    // Saturating run counter increment and one-hot of the active grant
    always_comb begin
        w_cnt_inc      = (r_cnt == c_cnt_max) ? r_cnt : (r_cnt + CYC_W'(1));
        w_grant_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_grant_onehot[i] = (r_grant_id == ID_W'(i));
        end
    end

    // Scheduler FSM; pulse outputs are registered so each one lines up
    // exactly with the state it belongs to (acc_start in START, ack and
    // rsp_valid in DONE)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_idle;
            r_grant_id    <= '0;
            r_last_grant  <= ID_W'(NUM_REQ - 1);
            r_cnt         <= '0;
            r_rsp_id      <= '0;
            r_rsp_val     <= '0;
            r_rsp_cycles  <= '0;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_ack         <= '0;
            r_acc_start   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_ack       <= '0;
            r_acc_start <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (w_found) begin
                        r_grant_id  <= w_pick;
                        r_acc_start <= 1'b1;
                        r_state     <= c_start;
                    end
                end
                c_start: begin
                    r_cnt   <= '0;
                    r_state <= c_exe;
                end
                c_exe: begin
                    // Finish takes priority over a coincident timeout
                    if (acc_finish) begin
                        r_rsp_val     <= acc_return_val;
                        r_rsp_id      <= r_grant_id;
                        r_rsp_cycles  <= w_cnt_inc;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_ack         <= w_grant_onehot;
                        r_state       <= c_done;
                    end else if (c_to_en && (r_cnt == c_to_last)) begin
                        r_rsp_val     <= '0;
                        r_rsp_id      <= r_grant_id;
                        r_rsp_cycles  <= c_to_cycles;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_ack         <= w_grant_onehot;
                        r_state       <= c_done;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                c_done: begin
                    r_last_grant <= r_grant_id;
                    r_state      <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    // A timed-out accelerator is reset during DONE so the next run starts clean
    assign acc_reset   = reset | ((r_state == c_done) & r_rsp_timeout);
    assign acc_start   = r_acc_start;
    assign ack         = r_ack;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_val     = r_rsp_val;
    assign rsp_cycles  = r_rsp_cycles;
    assign rsp_timeout = r_rsp_timeout;
    assign busy        = (r_state != c_idle);
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_accel_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_accel_rr_scheduler
//  Description : Self-checking bench for accel_rr_scheduler. Instance A
//                (TIMEOUT=16) carries the arbitration, run-length, timeout,
//                spurious-finish and reset-abort sequences; instance B
//                (TIMEOUT=8) covers the finish/timeout coincidence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_accel_rr_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [3:0]  req_a, ack_a;
    logic        rsp_valid_a, rsp_timeout_a, acc_start_a, acc_reset_a, fin_a, busy_a;
    logic [1:0]  rsp_id_a, state_a;
    logic [31:0] rsp_val_a, rsp_cycles_a, ret_a;

    logic [3:0]  req_b, ack_b;
    logic        rsp_valid_b, rsp_timeout_b, acc_start_b, acc_reset_b, fin_b, busy_b;
    logic [1:0]  rsp_id_b, state_b;
    logic [31:0] rsp_val_b, rsp_cycles_b, ret_b;

    always #5 clk = ~clk;

    accel_rr_scheduler #(.NUM_REQ(4), .ID_W(2), .CYC_W(32), .TIMEOUT(16)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .ack(ack_a),
        .rsp_valid(rsp_valid_a), .rsp_id(rsp_id_a), .rsp_val(rsp_val_a),
        .rsp_cycles(rsp_cycles_a), .rsp_timeout(rsp_timeout_a),
        .acc_start(acc_start_a), .acc_reset(acc_reset_a),
        .acc_finish(fin_a), .acc_return_val(ret_a),
        .busy(busy_a), .state(state_a)
    );

    accel_rr_scheduler #(.NUM_REQ(4), .ID_W(2), .CYC_W(32), .TIMEOUT(8)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .ack(ack_b),
        .rsp_valid(rsp_valid_b), .rsp_id(rsp_id_b), .rsp_val(rsp_val_b),
        .rsp_cycles(rsp_cycles_b), .rsp_timeout(rsp_timeout_b),
        .acc_start(acc_start_b), .acc_reset(acc_reset_b),
        .acc_finish(fin_b), .acc_return_val(ret_b),
        .busy(busy_b), .state(state_b)
    );

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  req_mid;
        int          fin;     // EXE cycle carrying finish; 0 = never
        logic [31:0] val;
        logic [1:0]  id;
        logic [31:0] cyc;
        logic        to;
    } vec_t;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] val;
        logic [31:0] cyc;
        logic        to;
    } exp_t;

    exp_t  sbq[$];
    exp_t  mon_e;
    logic [3:0] mon_ack;
    vec_t  vecs[14];
    int    errors = 0;
    int    checks = 0;
    int    starts_a = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_start(input bit sel_b, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sel_b ? acc_start_b : acc_start_a) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL start_wait: got no acc_start, required one within 20 cycles");
        end
    endtask

    task automatic wait_valid(input bit sel_b, input int limit);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (sel_b ? rsp_valid_b : rsp_valid_a) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL valid_wait: got no rsp_valid, required one within %0d cycles", limit);
        end
    endtask

    // One run on instance A; the response itself is checked by the monitor
    task automatic run_one(input vec_t v);
        exp_t e;
        bit   ok;
        e.id  = v.id;
        e.val = v.to ? 32'h0 : v.val;
        e.cyc = v.cyc;
        e.to  = v.to;
        sbq.push_back(e);
        req_a = v.req;
        wait_start(1'b0, ok);
        if (!ok) return;
        chk("start_state", 32'(state_a), 32'd1);
        chk("start_busy", 32'(busy_a), 32'd1);
        req_a = v.req_mid;
        if (v.fin > 0) begin
            repeat (v.fin) @(negedge clk);
            chk("exe_state", 32'(state_a), 32'd2);
            fin_a = 1'b1;
            ret_a = v.val;
            @(negedge clk);
            fin_a = 1'b0;
            ret_a = $urandom;
        end else begin
            wait_valid(1'b0, 40);
        end
    endtask

    // Response monitor / scoreboard for instance A plus per-cycle invariants
    always @(negedge clk) begin
        if (acc_start_a) starts_a++;
        chk("start_with_done", 32'(acc_start_a & (rsp_valid_a | (|ack_a))), 32'd0);
        chk("ack_without_valid", 32'((|ack_a) & ~rsp_valid_a), 32'd0);
        if (rsp_valid_a) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_id %0d, required no response", rsp_id_a);
            end else begin
                mon_e   = sbq.pop_front();
                mon_ack = 4'b0001 << mon_e.id;
                chk("rsp_id", 32'(rsp_id_a), 32'(mon_e.id));
                chk("rsp_val", rsp_val_a, mon_e.val);
                chk("rsp_cycles", rsp_cycles_a, mon_e.cyc);
                chk("rsp_timeout", 32'(rsp_timeout_a), 32'(mon_e.to));
                chk("ack", 32'(ack_a), 32'(mon_ack));
                chk("acc_reset_done", 32'(acc_reset_a), 32'(mon_e.to));
                chk("done_state", 32'(state_a), 32'd3);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish within 200000 time units");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit   ok;
        req_a = '0; fin_a = 1'b0; ret_a = '0;
        req_b = '0; fin_b = 1'b0; ret_b = '0;

        // Reset state (checked while reset is still asserted)
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_ack", 32'(ack_a), 32'd0);
        chk("rst_valid", 32'(rsp_valid_a), 32'd0);
        chk("rst_start", 32'(acc_start_a), 32'd0);
        chk("rst_acc_reset", 32'(acc_reset_a), 32'd1);
        chk("rst_rsp_val", rsp_val_a, 32'd0);
        chk("rst_rsp_cycles", rsp_cycles_a, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("acc_reset_released", 32'(acc_reset_a), 32'd0);

        //             req      req_mid  fin  val            id  cyc  to
        vecs[0]  = '{4'b1111, 4'b1111, 1, 32'h1000_0001, 2'd0, 32'd1,  1'b0};
        vecs[1]  = '{4'b1111, 4'b1111, 2, 32'h1000_0002, 2'd1, 32'd2,  1'b0};
        vecs[2]  = '{4'b1111, 4'b1111, 3, 32'h1000_0003, 2'd2, 32'd3,  1'b0};
        vecs[3]  = '{4'b1111, 4'b1111, 4, 32'h1000_0004, 2'd3, 32'd4,  1'b0};
        vecs[4]  = '{4'b1111, 4'b1111, 1, 32'h1000_0005, 2'd0, 32'd1,  1'b0};
        vecs[5]  = '{4'b1111, 4'b1111, 2, 32'h1000_0006, 2'd1, 32'd2,  1'b0};
        vecs[6]  = '{4'b1111, 4'b1111, 1, 32'h1000_0007, 2'd2, 32'd1,  1'b0};
        vecs[7]  = '{4'b1111, 4'b1111, 3, 32'h1000_0008, 2'd3, 32'd3,  1'b0};
        vecs[8]  = '{4'b0100, 4'b0100, 5, 32'h00AB_CDEF, 2'd2, 32'd5,  1'b0};
        vecs[9]  = '{4'b0010, 4'b0010, 0, 32'hDEAD_BEEF, 2'd1, 32'd16, 1'b1};
        vecs[10] = '{4'b1001, 4'b1001, 3, 32'h2222_0003, 2'd3, 32'd3,  1'b0};
        vecs[11] = '{4'b1001, 4'b1001, 2, 32'h2222_0004, 2'd0, 32'd2,  1'b0};
        vecs[12] = '{4'b0110, 4'b0001, 4, 32'h2222_0005, 2'd1, 32'd4,  1'b0};
        vecs[13] = '{4'b0100, 4'b0100, 1, 32'h2222_0006, 2'd2, 32'd1,  1'b0};

        for (int i = 0; i < 14; i++) begin
            run_one(vecs[i]);
        end

        // Finish held high through DONE, IDLE and START is ignored; the run
        // ends on the first EXE cycle
        req_a = '0;
        fin_a = 1'b1;
        ret_a = 32'h5A5A_0001;
        repeat (2) @(negedge clk);
        chk("spurious_idle_state", 32'(state_a), 32'd0);
        v = '{4'b0001, 4'b0001, 0, 32'h5A5A_0001, 2'd0, 32'd1, 1'b0};
        sbq.push_back('{v.id, v.val, v.cyc, v.to});
        req_a = 4'b0001;
        wait_start(1'b0, ok);
        @(negedge clk);
        chk("spurious_exe_state", 32'(state_a), 32'd2);
        @(negedge clk);
        fin_a = 1'b0;
        req_a = '0;

        // Reset on the 3rd EXE cycle aborts the run without ack
        @(negedge clk);
        req_a = 4'b1000;
        wait_start(1'b0, ok);
        repeat (3) @(negedge clk);
        chk("abort_exe_state", 32'(state_a), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_state", 32'(state_a), 32'd0);
        chk("abort_ack", 32'(ack_a), 32'd0);
        chk("abort_valid", 32'(rsp_valid_a), 32'd0);
        chk("abort_acc_reset", 32'(acc_reset_a), 32'd1);
        chk("abort_rsp_cycles", rsp_cycles_a, 32'd0);
        reset = 1'b0;
        v = '{4'b1111, 4'b1111, 2, 32'h7777_0001, 2'd0, 32'd2, 1'b0};
        run_one(v);
        req_a = '0;

        // Response fields hold after the run
        repeat (4) @(negedge clk);
        chk("hold_rsp_id", 32'(rsp_id_a), 32'd0);
        chk("hold_rsp_val", rsp_val_a, 32'h7777_0001);
        chk("hold_rsp_cycles", rsp_cycles_a, 32'd2);
        chk("hold_idle", 32'(state_a), 32'd0);
        chk("start_count", 32'(starts_a), 32'd17);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        // Instance B: finish on the 8th EXE cycle coincides with timeout
        req_b = 4'b0001;
        wait_start(1'b1, ok);
        repeat (8) @(negedge clk);
        chk("b_exe_state", 32'(state_b), 32'd2);
        fin_b = 1'b1;
        ret_b = 32'h55AA_1234;
        @(negedge clk);
        fin_b = 1'b0;
        req_b = '0;
        chk("b_coinc_valid", 32'(rsp_valid_b), 32'd1);
        chk("b_coinc_timeout", 32'(rsp_timeout_b), 32'd0);
        chk("b_coinc_cycles", rsp_cycles_b, 32'd8);
        chk("b_coinc_val", rsp_val_b, 32'h55AA_1234);
        chk("b_coinc_acc_reset", 32'(acc_reset_b), 32'd0);
        chk("b_coinc_ack", 32'(ack_b), 32'd1);

        // Instance B: no finish at all -> timeout after 8 EXE cycles
        @(negedge clk);
        req_b = 4'b0001;
        wait_start(1'b1, ok);
        wait_valid(1'b1, 30);
        req_b = '0;
        chk("b_to_timeout", 32'(rsp_timeout_b), 32'd1);
        chk("b_to_cycles", rsp_cycles_b, 32'd8);
        chk("b_to_val", rsp_val_b, 32'd0);
        chk("b_to_acc_reset", 32'(acc_reset_b), 32'd1);
        @(negedge clk);
        chk("b_to_acc_reset_clear", 32'(acc_reset_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
